dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: AW, 32, address width of requester and memory ports.
REQ-002 Parameter: DW, 32, data width of requester and memory ports.
REQ-003 Parameter: HOLD_MAX, 8, max consecutive granted cycles for one owner while the other port is requesting; legal range 2..255.
REQ-004 clk  input  1  single system clock, all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req0, we0  input  1 each  port 0 (core) request, write enable.
REQ-007 addr0 / wdata0  input  AW / DW  port 0 address, write data.
REQ-008 gnt0  output  1  port 0 owns memory this cycle.
REQ-009 rvalid0  output  1  port 0 read data valid; rdata0  output  DW  port 0 read data.
REQ-010 req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1: port 1 (loader/DMA), same widths and meanings as port 0.
REQ-011 mem_we  output  1; mem_addr  output  AW; mem_wdata  output  DW; mem_rdata  input  DW (combinational-read, clocked-write data memory).

Function
REQ-012 FSM states IDLE, OWN0, OWN1; gnt0 = (state==OWN0), gnt1 = (state==OWN1), both registered.
REQ-013 Access cycle for port i: gnt_i & req_i; memory outputs driven from port i (mem_we = we_i); otherwise mem_we = 0 and mem_addr/mem_wdata hold port 0 values.
REQ-014 Read latency: on an access cycle with we_i = 0, mem_rdata is registered into rdata_i and rvalid_i is 1 on the following cycle only; writes never raise rvalid_i.
REQ-015 rdata_i holds its last value when rvalid_i = 0.
REQ-016 IDLE: neither req -> IDLE; only req_i -> OWNi; both -> winner per REQ-021/REQ-022; no access occurs in IDLE.
REQ-017 OWNi: req_i = 0 -> IDLE (natural release); req_i & other req & hold_cnt == HOLD_MAX-1 -> IDLE (forced release); else stay.
REQ-018 hold_cnt (8 bit) increments on each access cycle, clears on every entry to IDLE; saturates, never wraps, when the other port is idle.
REQ-019 Every ownership change passes through one IDLE turnaround cycle; gnt0 & gnt1 never simultaneously 1.
REQ-020 Request dropped while granted: no access that cycle, no rvalid next cycle.
REQ-021 After forced release, the released port is lowest priority in the next IDLE arbitration (no starvation).
REQ-022 After natural release or reset, tie-break per Configuration.
REQ-023 addr/we/wdata of a requester are sampled only in its access cycle; changes while not granted are ignored.

Reset
REQ-024 Asserting reset, including mid-access, immediately forces state = IDLE, gnt0 = gnt1 = 0, rvalid0 = rvalid1 = 0, mem_we = 0, hold_cnt = 0, last-grant = port 1.
REQ-025 rdata0/rdata1 reset to 0; first arbitration after reset deasserts follows REQ-022.

Configuration
REQ-026 Macro DMEM_ARB_RR_EN defined: natural-release ties go to the port not most recently granted (round robin, last-grant register).
REQ-027 DMEM_ARB_RR_EN undefined: natural-release ties always go to port 0; forced-release rule REQ-021 still applies; last-grant register absent.

Verification
REQ-028 Reset, req0=1 we0=0 addr0=0x10, mem[0x10]=0xDEADBEEF -> gnt0 at cycle 1, rvalid0=1 rdata0=0xDEADBEEF at cycle 2.
REQ-029 req1=1 we1=1 addr1=0x20 wdata1=0x12345678 one access cycle, then port 0 reads 0x20 -> IDLE turnaround cycle, rdata0=0x12345678.
REQ-030 req0 and req1 held high continuously, HOLD_MAX=8 -> pattern 8 gnt0 cycles, 1 IDLE, 8 gnt1 cycles, 1 IDLE, repeating; never both grants.
REQ-031 Both req rise together after natural release by port 0: with DMEM_ARB_RR_EN port 1 wins; without it port 0 wins.
REQ-032 reset asserted asynchronously mid read access of port 1 -> gnt1, rvalid1, mem_we low before next clock edge; no rvalid1 pulse after reset release.
REQ-033 req0 dropped on its granted cycle with we0=1 -> mem_we stays 0, memory unchanged, state IDLE next cycle.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports and the data-memory port of dmem_arbiter.
// The slave modport is the arbiter; the master modport is the requesters plus the memory.
interface dmem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req0;
  logic          we0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0;
  logic          gnt0;
  logic          rvalid0;
  logic [DW-1:0] rdata0;

  logic          req1;
  logic          we1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1;
  logic          gnt1;
  logic          rvalid1;
  logic [DW-1:0] rdata1;

  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  mem_rdata,
    output gnt0, rvalid0, rdata0,
    output gnt1, rvalid1, rdata1,
    output mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output mem_rdata,
    input  gnt0, rvalid0, rdata0,
    input  gnt1, rvalid1, rdata1,
    input  mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: IDLE/OWN0/OWN1 ownership FSM with bounded hold and turnaround.
// Define DMEM_ARB_RR_EN for round-robin tie-break after natural release (default: port 0 wins ties).
module dmem_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int HOLD_MAX = 8
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  io_bus
);

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t        r_state, w_next;
  logic [7:0]    r_hold_cnt, w_hold_nxt;
  logic          r_forced, w_forced_nxt;
  logic          r_forced_port, w_forced_port_nxt;
  logic          r_rvalid0, r_rvalid1;
  logic [DW-1:0] r_rdata0, r_rdata1;

  logic          w_gnt0, w_gnt1;
  logic          w_acc0, w_acc1;
  logic          w_pick1;
  logic          w_mem_we;
  logic [AW-1:0] w_mem_addr;
  logic [DW-1:0] w_mem_wdata;

`ifdef DMEM_ARB_RR_EN
  logic          r_last_gnt;
`endif

  assign w_gnt0 = (r_state == OWN0);
  assign w_gnt1 = (r_state == OWN1);
  assign w_acc0 = w_gnt0 & io_bus.req0;
  assign w_acc1 = w_gnt1 & io_bus.req1;

  // Memory port follows the owner only on a real access; otherwise it parks on port 0 with no write.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_mem_we    = 1'b0;
    w_mem_addr  = io_bus.addr0;
    w_mem_wdata = io_bus.wdata0;
    if (w_acc1) begin
      w_mem_we    = io_bus.we1;
      w_mem_addr  = io_bus.addr1;
      w_mem_wdata = io_bus.wdata1;
    end else if (w_acc0) begin
      w_mem_we    = io_bus.we0;
    end
  end

  // Tie-break: a forcibly released port always loses the next contested arbitration.
  always_comb begin
    w_pick1 = 1'b0;
    if (r_forced) begin
      w_pick1 = ~r_forced_port;
    end else begin
`ifdef DMEM_ARB_RR_EN
      w_pick1 = ~r_last_gnt;
`else
      w_pick1 = 1'b0;
`endif
    end
  end

  always_comb begin
    w_next            = r_state;
    w_forced_nxt      = r_forced;
    w_forced_port_nxt = r_forced_port;
    unique case (r_state)
      IDLE: begin
        if (io_bus.req0 && io_bus.req1) w_next = w_pick1 ? OWN1 : OWN0;
        else if (io_bus.req0)           w_next = OWN0;
        else if (io_bus.req1)           w_next = OWN1;
        if (w_next != IDLE) w_forced_nxt = 1'b0;
      end
      OWN0: begin
        if (!io_bus.req0) begin
          w_next = IDLE;
        end else if (io_bus.req1 && (r_hold_cnt == HOLD_LAST)) begin
          w_next            = IDLE;
          w_forced_nxt      = 1'b1;
          w_forced_port_nxt = 1'b0;
        end
      end
      OWN1: begin
        if (!io_bus.req1) begin
          w_next = IDLE;
        end else if (io_bus.req0 && (r_hold_cnt == HOLD_LAST)) begin
          w_next            = IDLE;
          w_forced_nxt      = 1'b1;
          w_forced_port_nxt = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Counter stops at HOLD_LAST when uncontested, so a late requester waits at most one more access.
  always_comb begin
    w_hold_nxt = r_hold_cnt;
    if (w_next == IDLE) begin
      w_hold_nxt = 8'd0;
    end else if ((w_acc0 || w_acc1) && (r_hold_cnt != HOLD_LAST)) begin
      w_hold_nxt = r_hold_cnt + 8'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_hold_cnt    <= 8'd0;
      r_forced      <= 1'b0;
      r_forced_port <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_hold_cnt    <= w_hold_nxt;
      r_forced      <= w_forced_nxt;
      r_forced_port <= w_forced_port_nxt;
    end
  end

`ifdef DMEM_ARB_RR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_gnt <= 1'b1;
    end else if ((r_state == IDLE) && (w_next != IDLE)) begin
      r_last_gnt <= (w_next == OWN1);
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
    end else begin
      r_rvalid0 <= w_acc0 & ~io_bus.we0;
      r_rvalid1 <= w_acc1 & ~io_bus.we1;
      if (w_acc0 && !io_bus.we0) r_rdata0 <= io_bus.mem_rdata;
      if (w_acc1 && !io_bus.we1) r_rdata1 <= io_bus.mem_rdata;
    end
  end

  assign io_bus.gnt0      = w_gnt0;
  assign io_bus.gnt1      = w_gnt1;
  assign io_bus.rvalid0   = r_rvalid0;
  assign io_bus.rvalid1   = r_rvalid1;
  assign io_bus.rdata0    = r_rdata0;
  assign io_bus.rdata1    = r_rdata1;
  assign io_bus.mem_we    = w_mem_we;
  assign io_bus.mem_addr  = w_mem_addr;
  assign io_bus.mem_wdata = w_mem_wdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a read-data scoreboard and a behavioural data memory.
// Tie-break expectations follow DMEM_ARB_RR_EN when the bench is built with it.
module tb_dmem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic clk;
  logic reset;

  dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  dmem_arbiter #(.AW(AW), .DW(DW), .HOLD_MAX(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational-read, clocked-write memory, preloaded while reset is high.
  logic [31:0] mem [0:255];
  assign bus.mem_rdata = mem[bus.mem_addr[7:0]];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[8'h10] <= 32'hDEADBEEF;
    end else if (bus.mem_we) begin
      mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
    end
  end

  int n_cmp;
  int n_err;
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [1:0]  eg;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Samples at the falling edge: checks grants and retires any read result against the scoreboard.
  task automatic sample(input logic [1:0] exp_gnt, input string tag);
    @(negedge clk);
    check({tag, "_gnt"}, {30'b0, bus.gnt1, bus.gnt0}, {30'b0, exp_gnt});
    if (bus.rvalid0) begin
      if (q0.size() == 0) check({tag, "_rvalid0_unexpected"}, 32'(bus.rvalid0), 32'd0);
      else                check({tag, "_rdata0"}, bus.rdata0, q0.pop_front());
    end
    if (bus.rvalid1) begin
      if (q1.size() == 0) check({tag, "_rvalid1_unexpected"}, 32'(bus.rvalid1), 32'd0);
      else                check({tag, "_rdata1"}, bus.rdata1, q1.pop_front());
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    bus.req0 = r; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d;
  endtask

  task automatic drive1(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    bus.req1 = r; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    drive0(1'b0, 1'b0, 32'h0, 32'h0);
    drive1(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    sample(2'b00, "rst");
    check("rst_rvalid0", 32'(bus.rvalid0), 32'd0);
    check("rst_rvalid1", 32'(bus.rvalid1), 32'd0);
    check("rst_rdata0", bus.rdata0, 32'h0);
    check("rst_rdata1", bus.rdata1, 32'h0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    tick();

    // Port 0 read of 0x10: grant at cycle 1, data at cycle 2
    drive0(1'b1, 1'b0, 32'h10, 32'h0);
    sample(2'b00, "t1_idle");
    tick();
    q0.push_back(32'hDEADBEEF);
    sample(2'b01, "t1_acc");
    check("t1_mem_addr", bus.mem_addr, 32'h10);
    check("t1_mem_we", 32'(bus.mem_we), 32'd0);
    tick();
    drive0(1'b0, 1'b0, 32'h0, 32'h0);
    sample(2'b01, "t1_rel");
    check("t1_rvalid0", 32'(bus.rvalid0), 32'd1);
    tick();
    sample(2'b00, "t1_after");
    check("t1_rvalid0_once", 32'(bus.rvalid0), 32'd0);
    check("t1_rdata0_hold", bus.rdata0, 32'hDEADBEEF);
    tick();

    // Port 1 write, then port 0 reads it back through one turnaround cycle
    drive1(1'b1, 1'b1, 32'h20, 32'h12345678);
    sample(2'b00, "t2_idle");
    tick();
    sample(2'b10, "t2_wr");
    check("t2_mem_we", 32'(bus.mem_we), 32'd1);
    check("t2_mem_addr", bus.mem_addr, 32'h20);
    check("t2_mem_wdata", bus.mem_wdata, 32'h12345678);
    tick();
    drive1(1'b0, 1'b0, 32'h0, 32'h0);
    drive0(1'b1, 1'b0, 32'h20, 32'h0);
    sample(2'b10, "t2_rel");
    check("t2_no_rvalid1", 32'(bus.rvalid1), 32'd0);
    tick();
    sample(2'b00, "t2_turn");
    check("t2_mem_written", mem[8'h20], 32'h12345678);
    tick();
    q0.push_back(32'h12345678);
    sample(2'b01, "t2_rd");
    tick();
    drive0(1'b0, 1'b0, 32'h0, 32'h0);
    sample(2'b01, "t2_rel0");
    check("t2_rvalid0", 32'(bus.rvalid0), 32'd1);
    tick();
    sample(2'b00, "t2_end");
    tick();

    // Both requesting continuously: 8 x OWN0, IDLE, 8 x OWN1, IDLE, ...
    drive0(1'b1, 1'b0, 32'h10, 32'h0);
    sample(2'b00, "t3_idle");
    tick();
    drive1(1'b1, 1'b0, 32'h20, 32'h0);
    for (int k = 0; k < 36; k++) begin
      int ph;
      ph = k % 18;
      if (ph < 8)       eg = 2'b01;
      else if (ph == 8) eg = 2'b00;
      else if (ph < 17) eg = 2'b10;
      else              eg = 2'b00;
      if (eg == 2'b01) q0.push_back(32'hDEADBEEF);
      if (eg == 2'b10) q1.push_back(32'h12345678);
      sample(eg, "t3_pattern");
      tick();
    end
    drive0(1'b0, 1'b0, 32'h0, 32'h0);
    drive1(1'b0, 1'b0, 32'h0, 32'h0);
    sample(2'b01, "t3_drop");
    tick();
    sample(2'b00, "t3_after");
    check("t3_no_rvalid0", 32'(bus.rvalid0), 32'd0);
    tick();

    // Natural release by port 0, then both requests rise together
    drive0(1'b1, 1'b0, 32'h10, 32'h0);
    sample(2'b00, "t4_idle");
    tick();
    q0.push_back(32'hDEADBEEF);
    sample(2'b01, "t4_acc");
    tick();
    drive0(1'b0, 1'b0, 32'h0, 32'h0);
    sample(2'b01, "t4_rel");
    tick();
    drive0(1'b1, 1'b0, 32'h10, 32'h0);
    drive1(1'b1, 1'b0, 32'h20, 32'h0);
    sample(2'b00, "t4_arb");
`ifdef DMEM_ARB_RR_EN
    eg = 2'b10;
`else
    eg = 2'b01;
`endif
    tick();
    if (eg == 2'b10) q1.push_back(32'h12345678);
    else             q0.push_back(32'hDEADBEEF);
    sample(eg, "t4_tie");
    tick();
    drive0(1'b0, 1'b0, 32'h0, 32'h0);
    drive1(1'b0, 1'b0, 32'h0, 32'h0);
    sample(eg, "t4_rel2");
    tick();
    sample(2'b00, "t4_end");
    tick();

    // Write request dropped on its granted cycle: no write, back to IDLE
    drive0(1'b1, 1'b1, 32'h30, 32'hCAFEF00D);
    sample(2'b00, "t5_idle");
    tick();
    drive0(1'b0, 1'b1, 32'h30, 32'hCAFEF00D);
    sample(2'b01, "t5_drop");
    check("t5_mem_we", 32'(bus.mem_we), 32'd0);
    tick();
    drive0(1'b0, 1'b0, 32'h0, 32'h0);
    sample(2'b00, "t5_after");
    check("t5_mem_unchanged", mem[8'h30], 32'h0);
    check("t5_no_rvalid0", 32'(bus.rvalid0), 32'd0);
    tick();

    // Asynchronous reset in the middle of a port 1 read burst
    drive1(1'b1, 1'b0, 32'h20, 32'h0);
    sample(2'b00, "t6_idle");
    tick();
    q1.push_back(32'h12345678);
    sample(2'b10, "t6_acc");
    tick();
    check("t6_pre_gnt1", 32'(bus.gnt1), 32'd1);
    check("t6_pre_rvalid1", 32'(bus.rvalid1), 32'd1);
    if (q1.size() != 0) check("t6_pre_rdata1", bus.rdata1, q1.pop_front());
    #1 reset = 1'b1;
    #1;
    check("t6_rst_gnt1", 32'(bus.gnt1), 32'd0);
    check("t6_rst_gnt0", 32'(bus.gnt0), 32'd0);
    check("t6_rst_rvalid1", 32'(bus.rvalid1), 32'd0);
    check("t6_rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("t6_rst_rdata1", bus.rdata1, 32'h0);
    tick();
    drive1(1'b0, 1'b0, 32'h0, 32'h0);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sample(2'b00, "t6_post");
      check("t6_post_rvalid1", 32'(bus.rvalid1), 32'd0);
      tick();
    end

    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
